decode_packet: RTL and testbench

USB packet decoder: consumes the ULPI receive byte stream (one packet per AXI-S frame, `rx_tlast` on the final byte) and classifies it by PID. Handshakes and tokens are reported as single-cycle strobes with decoded fields. DATAx payloads are forwarded on an AXI-S output with the two CRC16 bytes stripped, followed by a CRC16 verdict. It is the receive-side counterpart of `encode_packet` and feeds the USB protocol/endpoint control logic.

---
 rtl/decode_packet.sv | 258 +++++++++++++++++++++++++
 tb/tb_decode_packet.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_packet.sv
// USB receive packet decoder: classifies ULPI packets by PID, reports handshakes and tokens,
// forwards DATAx payloads with CRC16 stripped. Build option DECODE_SOF_EN enables SOF decoding.
module decode_packet (
    input  logic        clock,
    input  logic        reset,
    input  logic        rx_tvalid_i,
    output logic        rx_tready_o,
    input  logic        rx_tlast_i,
    input  logic [7:0]  rx_tdata_i,
    output logic        hsk_recv_o,
    output logic [1:0]  hsk_type_o,
    output logic        tok_recv_o,
    output logic [1:0]  tok_type_o,
    output logic [6:0]  tok_addr_o,
    output logic [3:0]  tok_endp_o,
    output logic        sof_recv_o,
    output logic [10:0] sof_frame_o,
    output logic        trn_start_o,
    output logic [1:0]  trn_type_o,
    output logic        out_tvalid_o,
    input  logic        out_tready_i,
    output logic        out_tlast_o,
    output logic [7:0]  out_tdata_o,
    output logic        dat_done_o,
    output logic        dat_crc_ok_o,
    output logic        err_o
);

    localparam logic [4:0]  CRC5_RES  = 5'b01100;
    localparam logic [15:0] CRC16_RES = 16'hB001;

    typedef enum logic [1:0] {IDLE, TOKEN, DATA, DROP} state_t;

    state_t      state;
    logic        rdy_en;
    logic        done_pend;
    logic        crc_ok_pend;
    logic [1:0]  cnt;
    logic        tok_second;
    logic [7:0]  tok_b1;
    logic [1:0]  tok_kind;
    logic [7:0]  dly_p0;
    logic [7:0]  dly_p1;
    logic [15:0] crc16_q;

    logic        rx_fire;
    logic        out_free;
    logic [3:0]  pid;
    logic        pid_ok;
    logic [15:0] crc16_nxt;
    logic [4:0]  crc5_res;
    logic [10:0] tok_field;

    // Reflected CRC16 (poly 0x8005), data bits LSB first.
    function automatic logic [15:0] crc16_byte(input logic [15:0] c, input logic [7:0] d);
        logic [15:0] r;
        r = c;
        for (int i = 0; i < 8; i++) begin
            if (r[0] ^ d[i]) r = (r >> 1) ^ 16'hA001;
            else             r = r >> 1;
        end
        return r;
    endfunction

    // CRC5 residual over the 11 field bits plus the 5 transmitted CRC bits.
    function automatic logic [4:0] crc5_chk(input logic [15:0] bits);
        logic [4:0] r;
        r = 5'h1F;
        for (int i = 0; i < 16; i++) begin
            if (r[4] ^ bits[i]) r = {r[3:0], 1'b0} ^ 5'h05;
            else                r = {r[3:0], 1'b0};
        end
        return r;
    endfunction

    assign out_free  = !out_tvalid_o || out_tready_i;
    assign rx_fire   = rx_tvalid_i && rx_tready_o;
    assign pid       = rx_tdata_i[3:0];
    assign pid_ok    = (rx_tdata_i[7:4] == ~rx_tdata_i[3:0]);
    assign crc16_nxt = crc16_byte(crc16_q, rx_tdata_i);
    assign crc5_res  = crc5_chk({rx_tdata_i, tok_b1});
    assign tok_field = {rx_tdata_i[2:0], tok_b1};

    always_comb begin
        rx_tready_o = 1'b0;
        if (rdy_en) begin
            case (state)
                IDLE:  rx_tready_o = !dat_done_o;
                TOKEN: rx_tready_o = 1'b1;
                DATA:  rx_tready_o = !done_pend && out_free;
                DROP:  rx_tready_o = 1'b1;
            endcase
        end
    end

`ifndef DECODE_SOF_EN
    assign sof_recv_o  = 1'b0;
    assign sof_frame_o = 11'd0;
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            rdy_en       <= 1'b0;
            done_pend    <= 1'b0;
            cnt          <= 2'd0;
            tok_second   <= 1'b0;
            hsk_recv_o   <= 1'b0;
            hsk_type_o   <= 2'd0;
            tok_recv_o   <= 1'b0;
            tok_type_o   <= 2'd0;
            tok_addr_o   <= 7'd0;
            tok_endp_o   <= 4'd0;
`ifdef DECODE_SOF_EN
            sof_recv_o   <= 1'b0;
            sof_frame_o  <= 11'd0;
`endif
            trn_start_o  <= 1'b0;
            trn_type_o   <= 2'd0;
            out_tvalid_o <= 1'b0;
            out_tlast_o  <= 1'b0;
            out_tdata_o  <= 8'd0;
            dat_done_o   <= 1'b0;
            dat_crc_ok_o <= 1'b0;
            err_o        <= 1'b0;
        end else begin
            rdy_en      <= 1'b1;
            hsk_recv_o  <= 1'b0;
            tok_recv_o  <= 1'b0;
`ifdef DECODE_SOF_EN
            sof_recv_o  <= 1'b0;
`endif
            trn_start_o <= 1'b0;
            dat_done_o  <= 1'b0;
            err_o       <= 1'b0;
            if (out_tvalid_o && out_tready_i) begin
                out_tvalid_o <= 1'b0;
                out_tlast_o  <= 1'b0;
            end

            case (state)
                IDLE: if (rx_fire) begin
                    if (!pid_ok) begin
                        err_o <= 1'b1;
                        if (!rx_tlast_i) state <= DROP;
                    end else begin
                        case (pid[1:0])
                            2'b10: if (rx_tlast_i) begin
                                hsk_recv_o <= 1'b1;
                                hsk_type_o <= pid[3:2];
                            end else begin
                                err_o <= 1'b1;
                                state <= DROP;
                            end
                            2'b01: begin
`ifndef DECODE_SOF_EN
                                // SOF is swallowed without complaint when not decoded.
                                if (pid[3:2] == 2'b01) begin
                                    if (!rx_tlast_i) state <= DROP;
                                end else
`endif
                                if (rx_tlast_i) begin
                                    err_o <= 1'b1;
                                end else begin
                                    tok_kind   <= pid[3:2];
                                    tok_second <= 1'b0;
                                    state      <= TOKEN;
                                end
                            end
                            2'b11: begin
                                trn_start_o <= 1'b1;
                                trn_type_o  <= pid[3:2];
                                crc16_q     <= 16'hFFFF;
                                cnt         <= 2'd0;
                                if (rx_tlast_i) begin
                                    err_o        <= 1'b1;
                                    dat_crc_ok_o <= 1'b0;
                                end else begin
                                    state <= DATA;
                                end
                            end
                            2'b00: begin
                                err_o <= 1'b1;
                                if (!rx_tlast_i) state <= DROP;
                            end
                        endcase
                    end
                end

                TOKEN: if (rx_fire) begin
                    if (!tok_second) begin
                        tok_b1     <= rx_tdata_i;
                        tok_second <= 1'b1;
                        if (rx_tlast_i) begin
                            err_o <= 1'b1;
                            state <= IDLE;
                        end
                    end else if (!rx_tlast_i) begin
                        err_o <= 1'b1;
                        state <= DROP;
                    end else begin
                        state <= IDLE;
                        if (crc5_res != CRC5_RES) begin
                            err_o <= 1'b1;
                        end
`ifdef DECODE_SOF_EN
                        else if (tok_kind == 2'b01) begin
                            sof_recv_o  <= 1'b1;
                            sof_frame_o <= tok_field;
                        end
`endif
                        else begin
                            tok_recv_o <= 1'b1;
                            tok_type_o <= tok_kind;
                            tok_addr_o <= tok_field[6:0];
                            tok_endp_o <= tok_field[10:7];
                        end
                    end
                end

                // Two-byte delay line: a byte leaves only once two more have arrived.
                DATA: if (done_pend) begin
                    if (out_free) begin
                        dat_done_o   <= 1'b1;
                        dat_crc_ok_o <= crc_ok_pend;
                        done_pend    <= 1'b0;
                        cnt          <= 2'd0;
                        state        <= IDLE;
                    end
                end else if (rx_fire) begin
                    crc16_q <= crc16_nxt;
                    dly_p0  <= rx_tdata_i;
                    dly_p1  <= dly_p0;
                    if (cnt == 2'd2) begin
                        out_tvalid_o <= 1'b1;
                        out_tdata_o  <= dly_p1;
                        out_tlast_o  <= rx_tlast_i;
                    end else begin
                        cnt <= cnt + 2'd1;
                    end
                    if (rx_tlast_i) begin
                        if (cnt == 2'd0) begin
                            err_o        <= 1'b1;
                            dat_crc_ok_o <= 1'b0;
                            state        <= IDLE;
                        end else begin
                            done_pend   <= 1'b1;
                            crc_ok_pend <= (crc16_nxt == CRC16_RES);
                        end
                    end
                end

                DROP: if (rx_fire && rx_tlast_i) state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_packet.sv
// Scoreboard bench for decode_packet: expected strobes and beats are queued as packets are
// driven and matched in arrival order by a negedge monitor.
module tb_decode_packet;

    logic        clock = 1'b0;
    logic        reset;
    logic        rx_tvalid_i;
    logic        rx_tready_o;
    logic        rx_tlast_i;
    logic [7:0]  rx_tdata_i;
    logic        hsk_recv_o;
    logic [1:0]  hsk_type_o;
    logic        tok_recv_o;
    logic [1:0]  tok_type_o;
    logic [6:0]  tok_addr_o;
    logic [3:0]  tok_endp_o;
    logic        sof_recv_o;
    logic [10:0] sof_frame_o;
    logic        trn_start_o;
    logic [1:0]  trn_type_o;
    logic        out_tvalid_o;
    logic        out_tready_i = 1'b1;
    logic        out_tlast_o;
    logic [7:0]  out_tdata_o;
    logic        dat_done_o;
    logic        dat_crc_ok_o;
    logic        err_o;

    decode_packet dut (
        .clock(clock), .reset(reset),
        .rx_tvalid_i(rx_tvalid_i), .rx_tready_o(rx_tready_o),
        .rx_tlast_i(rx_tlast_i), .rx_tdata_i(rx_tdata_i),
        .hsk_recv_o(hsk_recv_o), .hsk_type_o(hsk_type_o),
        .tok_recv_o(tok_recv_o), .tok_type_o(tok_type_o),
        .tok_addr_o(tok_addr_o), .tok_endp_o(tok_endp_o),
        .sof_recv_o(sof_recv_o), .sof_frame_o(sof_frame_o),
        .trn_start_o(trn_start_o), .trn_type_o(trn_type_o),
        .out_tvalid_o(out_tvalid_o), .out_tready_i(out_tready_i),
        .out_tlast_o(out_tlast_o), .out_tdata_o(out_tdata_o),
        .dat_done_o(dat_done_o), .dat_crc_ok_o(dat_crc_ok_o), .err_o(err_o)
    );

    always #5 clock = ~clock;

    localparam int EV_HSK = 1, EV_TOK = 2, EV_SOF = 3, EV_TRN = 4, EV_BEAT = 5, EV_DONE = 6, EV_ERR = 7;

    typedef struct {
        int          kind;
        logic [31:0] val;
    } ev_t;

    ev_t         exp_q[$];
    logic [7:0]  pkt[$];
    logic [7:0]  pay[$];
    int          total = 0;
    int          bad = 0;
    int          rdy_mode = 0;
    logic        hold_v = 1'b0;
    logic [8:0]  hold_d;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic string kname(input int k);
        case (k)
            EV_HSK:  return "hsk";
            EV_TOK:  return "tok";
            EV_SOF:  return "sof";
            EV_TRN:  return "trn";
            EV_BEAT: return "beat";
            EV_DONE: return "done";
            EV_ERR:  return "err";
            default: return "none";
        endcase
    endfunction

    task automatic push(input int k, input logic [31:0] v);
        ev_t e;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input int k, input logic [31:0] v);
        ev_t e;
        logic [7:0] kb;
        logic [7:0] eb;
        kb = k[7:0];
        if (exp_q.size() == 0) begin
            check_val({"unexpected_", kname(k)}, {kb, v[23:0]}, 32'd0);
        end else begin
            e  = exp_q.pop_front();
            eb = e.kind[7:0];
            check_val({"ev_", kname(e.kind)}, {kb, v[23:0]}, {eb, e.val[23:0]});
        end
    endtask

    always @(negedge clock) begin
        if (reset) begin
            hold_v = 1'b0;
        end else begin
            if (hold_v) check_val("out_hold", {23'd0, out_tvalid_o, out_tlast_o, out_tdata_o}, {23'd0, 1'b1, hold_d});
            hold_v = out_tvalid_o && !out_tready_i;
            hold_d = {out_tlast_o, out_tdata_o};
            if (trn_start_o)                 observe(EV_TRN, {30'd0, trn_type_o});
            if (out_tvalid_o && out_tready_i) observe(EV_BEAT, {23'd0, out_tlast_o, out_tdata_o});
            if (hsk_recv_o)                  observe(EV_HSK, {30'd0, hsk_type_o});
            if (tok_recv_o)                  observe(EV_TOK, {19'd0, tok_type_o, tok_addr_o, tok_endp_o});
            if (sof_recv_o)                  observe(EV_SOF, {21'd0, sof_frame_o});
            if (dat_done_o)                  observe(EV_DONE, {31'd0, dat_crc_ok_o});
            if (err_o)                       observe(EV_ERR, 32'd0);
        end
    end

    always @(posedge clock) begin
        #1;
        case (rdy_mode)
            0:       out_tready_i = 1'b1;
            1:       out_tready_i = ~out_tready_i;
            default: out_tready_i = ($urandom_range(0, 1) == 1);
        endcase
    end

    // USB CRC5 in x^4..x^0 register order; returned bits in wire order (bit 0 sent first).
    function automatic logic [4:0] crc5_tx(input logic [10:0] f);
        logic [4:0] c;
        logic [4:0] t;
        logic       fb;
        c = 5'b11111;
        for (int i = 0; i < 11; i++) begin
            fb = c[4] ^ f[i];
            c  = {c[3:0], 1'b0} ^ (fb ? 5'b00101 : 5'b00000);
        end
        for (int k = 0; k < 5; k++) t[k] = ~c[4-k];
        return t;
    endfunction

    // USB CRC16 over pay[], non-reflected register; result in wire order (low byte sent first).
    function automatic logic [15:0] crc16_tx();
        logic [15:0] c;
        logic [15:0] t;
        logic        fb;
        c = 16'hFFFF;
        foreach (pay[j]) begin
            for (int i = 0; i < 8; i++) begin
                fb = c[15] ^ pay[j][i];
                c  = {c[14:0], 1'b0} ^ (fb ? 16'h8005 : 16'h0000);
            end
        end
        for (int k = 0; k < 16; k++) t[k] = ~c[15-k];
        return t;
    endfunction

    task automatic send_pkt();
        int n;
        for (int i = 0; i < pkt.size(); i++) begin
            rx_tvalid_i = 1'b1;
            rx_tdata_i  = pkt[i];
            rx_tlast_i  = (i == pkt.size() - 1);
            n = 0;
            while (!rx_tready_o && n < 300) begin
                @(negedge clock);
                n++;
            end
            if (n >= 300) begin
                check_val("rx_ready_timeout", {31'd0, rx_tready_o}, 32'd1);
                break;
            end
            @(negedge clock);
        end
        rx_tvalid_i = 1'b0;
        rx_tlast_i  = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 1000) begin
            @(negedge clock);
            n++;
        end
        if (n >= 1000) begin
            check_val("drain_timeout", exp_q.size(), 32'd0);
            exp_q.delete();
        end
        repeat (4) @(negedge clock);
    endtask

    task automatic send_raw(input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                            input logic [7:0] b3, input int len);
        logic [7:0] b[4];
        b[0] = b0; b[1] = b1; b[2] = b2; b[3] = b3;
        pkt.delete();
        for (int i = 0; i < len; i++) pkt.push_back(b[i]);
        send_pkt();
        drain();
    endtask

    task automatic token_pkt(input logic [7:0] pid, input logic [10:0] field, input int extra, input bit flip);
        logic [7:0] b2;
        b2 = {crc5_tx(field), field[10:8]};
        if (flip) b2[5] = ~b2[5];
        pkt.delete();
        pkt.push_back(pid);
        pkt.push_back(field[7:0]);
        pkt.push_back(b2);
        for (int i = 0; i < extra; i++) pkt.push_back(8'h00);
        send_pkt();
        drain();
    endtask

    task automatic data_pkt(input logic [7:0] pid, input int bad_idx);
        logic [15:0] c;
        c = crc16_tx();
        if (bad_idx >= 0) pay[bad_idx] = pay[bad_idx] ^ 8'h04;
        pkt.delete();
        pkt.push_back(pid);
        foreach (pay[i]) pkt.push_back(pay[i]);
        pkt.push_back(c[7:0]);
        pkt.push_back(c[15:8]);
        push(EV_TRN, {30'd0, pid[3:2]});
        for (int i = 0; i < pay.size(); i++)
            push(EV_BEAT, {23'd0, (i == pay.size() - 1), pay[i]});
        push(EV_DONE, {31'd0, (bad_idx < 0)});
        send_pkt();
        drain();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] dpids[4];
        dpids[0] = 8'hC3; dpids[1] = 8'h4B; dpids[2] = 8'h87; dpids[3] = 8'h0F;
        reset       = 1'b1;
        rx_tvalid_i = 1'b0;
        rx_tlast_i  = 1'b0;
        rx_tdata_i  = 8'h00;
        repeat (3) @(negedge clock);
        check_val("rst_ready", {31'd0, rx_tready_o}, 32'd0);
        check_val("rst_strobes", {23'd0, hsk_recv_o, tok_recv_o, sof_recv_o, trn_start_o, dat_done_o,
                                  err_o, out_tvalid_o, out_tlast_o, dat_crc_ok_o}, 32'd0);
        check_val("rst_fields", {15'd0, hsk_type_o, tok_type_o, tok_addr_o, tok_endp_o, trn_type_o}, 32'd0);
        check_val("rst_sof", {21'd0, sof_frame_o}, 32'd0);
        reset = 1'b0;
        check_val("ready_at_release", {31'd0, rx_tready_o}, 32'd0);
        @(negedge clock);
        check_val("ready_after_release", {31'd0, rx_tready_o}, 32'd1);

        // Handshakes
        push(EV_HSK, 32'd0);  send_raw(8'hD2, 8'h00, 8'h00, 8'h00, 1);
        push(EV_HSK, 32'd3);  send_raw(8'h1E, 8'h00, 8'h00, 8'h00, 1);
        push(EV_HSK, 32'd1);  send_raw(8'h96, 8'h00, 8'h00, 8'h00, 1);
        push(EV_HSK, 32'd2);  send_raw(8'h5A, 8'h00, 8'h00, 8'h00, 1);
        // Handshake PID followed by extra bytes, then a bad PID check, each recovering on ACK
        push(EV_ERR, 32'd0);  send_raw(8'h5A, 8'h11, 8'h22, 8'h33, 4);
        push(EV_HSK, 32'd0);  send_raw(8'hD2, 8'h00, 8'h00, 8'h00, 1);
        push(EV_ERR, 32'd0);  send_raw(8'h55, 8'hD2, 8'h22, 8'h33, 4);
        push(EV_HSK, 32'd0);  send_raw(8'hD2, 8'h00, 8'h00, 8'h00, 1);
        // Special PID (PRE)
        push(EV_ERR, 32'd0);  send_raw(8'h3C, 8'h01, 8'h00, 8'h00, 2);

        // Tokens
        push(EV_TOK, {19'd0, 2'b10, 7'h15, 4'h1});
        token_pkt(8'h69, {4'h1, 7'h15}, 0, 1'b0);
        push(EV_ERR, 32'd0);
        token_pkt(8'h69, {4'h1, 7'h15}, 0, 1'b1);
        push(EV_TOK, {19'd0, 2'b00, 7'h7F, 4'hF});
        token_pkt(8'hE1, {4'hF, 7'h7F}, 0, 1'b0);
        push(EV_TOK, {19'd0, 2'b11, 7'h00, 4'h0});
        send_raw(8'h2D, 8'h00, 8'h10, 8'h00, 3);
        push(EV_ERR, 32'd0);
        token_pkt(8'h69, {4'h2, 7'h33}, 1, 1'b0);
        push(EV_ERR, 32'd0);  send_raw(8'h69, 8'h15, 8'h00, 8'h00, 2);
        push(EV_HSK, 32'd0);  send_raw(8'hD2, 8'h00, 8'h00, 8'h00, 1);

        // SOF frame 0x123
`ifdef DECODE_SOF_EN
        push(EV_SOF, 32'h123);
`endif
        token_pkt(8'hA5, 11'h123, 0, 1'b0);
        push(EV_HSK, 32'd0);  send_raw(8'hD2, 8'h00, 8'h00, 8'h00, 1);

        // DATA1 with toggling output ready, then the same with a corrupted payload byte
        rdy_mode = 1;
        pay.delete(); pay.push_back(8'h01); pay.push_back(8'h02); pay.push_back(8'h03);
        data_pkt(8'h4B, -1);
        pay.delete(); pay.push_back(8'h01); pay.push_back(8'h02); pay.push_back(8'h03);
        data_pkt(8'h4B, 1);
        rdy_mode = 0;

        // Zero-length DATA0 as fixed bytes, too-short DATA0, then ACK
        push(EV_TRN, 32'd0); push(EV_DONE, 32'd1);
        send_raw(8'hC3, 8'h00, 8'h00, 8'h00, 3);
        push(EV_TRN, 32'd0); push(EV_ERR, 32'd0);
        send_raw(8'hC3, 8'h00, 8'h00, 8'h00, 2);
        push(EV_HSK, 32'd0);  send_raw(8'hD2, 8'h00, 8'h00, 8'h00, 1);

        // Randomised data packets under varied backpressure
        for (int p = 0; p < 10; p++) begin
            int n;
            rdy_mode = p % 3;
            n = $urandom_range(0, 12);
            pay.delete();
            for (int i = 0; i < n; i++) pay.push_back(8'($urandom_range(0, 255)));
            data_pkt(dpids[p % 4], (p == 7 && n > 0) ? 0 : -1);
            push(EV_HSK, 32'd2);  send_raw(8'h5A, 8'h00, 8'h00, 8'h00, 1);
        end
        rdy_mode = 0;
        repeat (5) @(negedge clock);

        check_val("leftover_expected", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
